uart_echo_fifo: RTL and testbench

- Buffers bytes from the UART receiver (rx_data/rx_valid) in a small FIFO.
- On a rising edge of the debounced button, it replays every buffered byte, in order, to the UART transmitter through its valid/ready interface.
- Sits between the receive path and the transmit path. In the top level it replaces the fixed-ID sender as the source for the transmitter whenever echo mode is wanted.

---
 rtl/uart_echo_fifo.sv | 142 ++++++++++++++
 tb/tb_uart_echo_fifo.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_fifo.sv
// Byte FIFO fed by the UART receiver; a rising edge on the debounced button replays
// every buffered byte, in order, to the transmitter over a valid/ready handshake.
module uart_echo_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              trigger,
    input  logic              uart_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, SEND, WAIT_LOW, WAIT_HIGH} state_t;

    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [7:0]        mem_q [DEPTH];
    logic [7:0]        mem_d [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              trig_q, trig_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        tx_data_q, tx_data_d;

    logic full, start, push, pop, load;

    always_comb begin
        full  = (count_q == FULL_COUNT);
        start = trigger & ~trig_q;
        push  = rx_valid & ~full;
        pop   = (state_q == SEND) & tx_valid_q & uart_ready;

        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        trig_d     = trigger;
        state_d    = state_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        load       = 1'b0;

        if (push) begin
            mem_d[wr_ptr_q] = rx_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                if (start && count_q != '0) begin
                    state_d    = SEND;
                    load       = 1'b1;
                    overflow_d = 1'b0;
                end
            end
            SEND: begin
                if (pop) begin
                    state_d    = WAIT_LOW;
                    tx_valid_d = 1'b0;
                end
            end
            WAIT_LOW: begin
                // ready must fall first so one transmitter frame never sees two pops
                if (!uart_ready) begin
                    state_d = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (uart_ready) begin
                    if (count_q != '0) begin
                        state_d = SEND;
                        load    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // No pop occurs in IDLE or WAIT_HIGH, so rd_ptr_q already names the next byte.
        if (load) begin
            tx_valid_d = 1'b1;
            tx_data_d  = mem_q[rd_ptr_q];
        end

        if (rx_valid && full) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            trig_q     <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            trig_q     <= trig_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Bench for uart_echo_fifo: vector table, directed corner sequences and randomized
// rounds checked against a queue-based FIFO model plus a transmitter model.
module tb_uart_echo_fifo;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              trigger = 1'b0;
    logic              uart_ready = 1'b1;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              busy;

    uart_echo_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .trigger(trigger), .uart_ready(uart_ready), .tx_data(tx_data),
        .tx_valid(tx_valid), .count(count), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [7:0] mq[$];
    logic [7:0] sent_q[$];
    logic       m_ovf = 1'b0;
    bit         bench_idle = 1'b1;
    bit         trig_last = 1'b0;
    bit         tx_auto = 1'b0;
    int         hold_fixed = 0;
    bit         drop_pending = 1'b0;
    int         low_left = 0;
    bit         prev_txv = 1'b0;
    logic [7:0] prev_txd = 8'h00;
    bit         hs, mfull;

    // Monitor: samples 2ns after each falling edge, i.e. the values the next rising edge sees.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            check("count_vs_model", 32'(count), 32'(mq.size()));
            check("overflow_vs_model", 32'(overflow), 32'(m_ovf));
            if (tx_valid && prev_txv) check("tx_data_stable", 32'(tx_data), 32'(prev_txd));
            prev_txv = tx_valid;
            prev_txd = tx_data;
            if (tx_auto) begin
                if (drop_pending) begin
                    uart_ready   = 1'b0;
                    low_left     = (hold_fixed > 0) ? hold_fixed : int'($urandom_range(1, 12));
                    drop_pending = 1'b0;
                end else if (low_left > 0) begin
                    low_left--;
                    if (low_left == 0) uart_ready = 1'b1;
                end
            end
            if (rst) begin
                mq.delete();
                m_ovf      = 1'b0;
                trig_last  = 1'b0;
                bench_idle = 1'b1;
            end else begin
                hs    = tx_valid && uart_ready;
                mfull = (mq.size() == DEPTH);
                if (trigger && !trig_last && bench_idle && mq.size() > 0) begin
                    m_ovf      = 1'b0;
                    bench_idle = 1'b0;
                end
                trig_last = trigger;
                if (hs) begin
                    sent_q.push_back(tx_data);
                    if (tx_auto) drop_pending = 1'b1;
                    if (mq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL tx_extra_byte: got handshake with %0h, required none (model empty) at %0t", tx_data, $time);
                    end else begin
                        check("tx_byte_order", 32'(tx_data), 32'(mq.pop_front()));
                    end
                end
                if (rx_valid) begin
                    if (!mfull) mq.push_back(rx_data);
                    else m_ovf = 1'b1;
                end
            end
        end
    end

    typedef struct {
        bit         rst, rxv;
        logic [7:0] rxd;
        bit         trig, rdy;
        int         exp_count;
        bit         exp_ovf, exp_txv, exp_busy;
        logic [7:0] exp_txd;
    } vec_t;

    vec_t tbl[16];

    // All stimulus tasks start and end at a falling edge.
    task automatic push(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        rx_valid = 1'b0;
        trigger = 1'b0;
        uart_ready = 1'b1;
        drop_pending = 1'b0;
        low_left = 0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        sent_q.delete();
    endtask

    task automatic drain(input int budget, input bit rand_push);
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < budget) begin
            if (rand_push && mq.size() > 0 && n < 60 && $urandom_range(0, 4) == 0) begin
                rx_valid = 1'b1;
                rx_data  = 8'($urandom);
            end else begin
                rx_valid = 1'b0;
            end
            @(negedge clk);
            n++;
            if (mq.size() == 0 && uart_ready && low_left == 0 && !drop_pending && !rx_valid) quiet++;
            else quiet = 0;
        end
        rx_valid = 1'b0;
        checks++;
        if (quiet < 3) begin
            failures++;
            $display("FAIL drain_timeout: got %0d bytes left after %0d cycles, required 0", mq.size(), n);
        end
        check("busy_after_drain", 32'(busy), 32'(0));
        bench_idle = 1'b1;
    endtask

    initial begin
        logic [7:0] echo_bytes[4];
        int cyc;
        int k;

        //            rst rxv rxd    trig rdy cnt ovf txv busy txd
        tbl[0]  = '{1, 0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00};
        tbl[1]  = '{1, 0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00};
        tbl[2]  = '{1, 0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00};
        tbl[3]  = '{0, 1, 8'hA5, 0, 1, 1, 0, 0, 0, 8'h00};
        tbl[4]  = '{0, 1, 8'h5A, 0, 1, 2, 0, 0, 0, 8'h00};
        tbl[5]  = '{0, 0, 8'h00, 1, 1, 2, 0, 1, 1, 8'hA5};
        tbl[6]  = '{0, 0, 8'h00, 1, 1, 1, 0, 0, 1, 8'hA5};
        tbl[7]  = '{0, 0, 8'h00, 1, 0, 1, 0, 0, 1, 8'hA5};
        tbl[8]  = '{0, 0, 8'h00, 1, 0, 1, 0, 0, 1, 8'hA5};
        tbl[9]  = '{0, 0, 8'h00, 1, 1, 1, 0, 1, 1, 8'h5A};
        tbl[10] = '{0, 0, 8'h00, 1, 0, 1, 0, 1, 1, 8'h5A};
        tbl[11] = '{0, 0, 8'h00, 1, 1, 0, 0, 0, 1, 8'h5A};
        tbl[12] = '{0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 8'h5A};
        tbl[13] = '{0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h5A};
        tbl[14] = '{0, 0, 8'h00, 1, 1, 0, 0, 0, 0, 8'h5A};
        tbl[15] = '{0, 1, 8'h11, 0, 1, 1, 0, 0, 0, 8'h5A};

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rst        = tbl[i].rst;
            rx_valid   = tbl[i].rxv;
            rx_data    = tbl[i].rxd;
            trigger    = tbl[i].trig;
            uart_ready = tbl[i].rdy;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].exp_count));
            check($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(tbl[i].exp_ovf));
            check($sformatf("vec%0d_tx_valid", i), 32'(tx_valid), 32'(tbl[i].exp_txv));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
            check($sformatf("vec%0d_tx_data", i), 32'(tx_data), 32'(tbl[i].exp_txd));
        end
        @(negedge clk);
        rx_valid = 1'b0;
        trigger  = 1'b0;
        bench_idle = 1'b1;
        tx_auto  = 1'b1;

        // Reset state and basic echo
        do_reset(3);
        check("rst_count", 32'(count), 32'(0));
        check("rst_overflow", 32'(overflow), 32'(0));
        check("rst_tx_valid", 32'(tx_valid), 32'(0));
        check("rst_tx_data", 32'(tx_data), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        hold_fixed = 10;
        echo_bytes = '{8'h32, 8'h30, 8'h32, 8'h34};
        for (int i = 0; i < 4; i++) push(echo_bytes[i]);
        check("echo_count_before", 32'(count), 32'(4));
        pulse_trigger();
        drain(500, 1'b0);
        check("echo_handshakes", 32'(sent_q.size()), 32'(4));
        for (int i = 0; i < 4 && i < sent_q.size(); i++)
            check($sformatf("echo_byte%0d", i), 32'(sent_q[i]), 32'(echo_bytes[i]));
        check("echo_count_after", 32'(count), 32'(0));

        // Full / overflow
        do_reset(2);
        hold_fixed = 0;
        for (int i = 0; i < 17; i++) push(8'(i));
        check("full_count", 32'(count), 32'(16));
        check("full_overflow", 32'(overflow), 32'(1));
        pulse_trigger();
        check("ovf_cleared_on_start", 32'(overflow), 32'(0));
        check("busy_on_start", 32'(busy), 32'(1));
        drain(2000, 1'b0);
        check("full_handshakes", 32'(sent_q.size()), 32'(16));
        for (int i = 0; i < 16 && i < sent_q.size(); i++)
            check($sformatf("full_byte%0d", i), 32'(sent_q[i]), 32'(i));

        // Wrap-around
        do_reset(2);
        for (int i = 0; i < 12; i++) push(8'(8'h80 + i));
        pulse_trigger();
        drain(2000, 1'b0);
        sent_q.delete();
        for (int i = 0; i < 10; i++) push(8'(8'hC0 + i));
        check("wrap_count", 32'(count), 32'(10));
        pulse_trigger();
        drain(2000, 1'b0);
        check("wrap_handshakes", 32'(sent_q.size()), 32'(10));
        for (int i = 0; i < 10 && i < sent_q.size(); i++)
            check($sformatf("wrap_byte%0d", i), 32'(sent_q[i]), 32'(8'hC0 + i));
        check("wrap_count_after", 32'(count), 32'(0));

        // Push on the handshake cycle, trigger held high for 1000 cycles
        do_reset(2);
        hold_fixed = 3;
        push(8'hA0); push(8'hA1); push(8'hA2);
        trigger = 1'b1;
        cyc = 0;
        while (!tx_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("simul_tx_valid_seen", 32'(tx_valid), 32'(1));
        rx_valid = 1'b1;
        rx_data  = 8'hA3;
        @(negedge clk);
        cyc++;
        rx_valid = 1'b0;
        check("simul_count_unchanged", 32'(count), 32'(3));
        while (cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        drain(200, 1'b0);
        check("simul_handshakes", 32'(sent_q.size()), 32'(4));
        for (int i = 0; i < 4 && i < sent_q.size(); i++)
            check($sformatf("simul_byte%0d", i), 32'(sent_q[i]), 32'(8'hA0 + i));
        push(8'hB0); push(8'hB1);
        repeat (20) @(negedge clk);
        check("held_no_retrigger_count", 32'(count), 32'(2));
        check("held_no_retrigger_sent", 32'(sent_q.size()), 32'(4));
        check("held_no_retrigger_busy", 32'(busy), 32'(0));
        trigger = 1'b0;

        // Trigger while empty
        do_reset(2);
        trigger = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("empty_trig_tx_valid", 32'(tx_valid), 32'(0));
            check("empty_trig_busy", 32'(busy), 32'(0));
        end
        trigger = 1'b0;

        // Reset in WAIT_LOW
        do_reset(2);
        hold_fixed = 8;
        push(8'h61); push(8'h62); push(8'h63);
        pulse_trigger();
        cyc = 0;
        while (!tx_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_tx_valid_seen", 32'(tx_valid), 32'(1));
        @(negedge clk);
        check("mid_count_before_rst", 32'(count), 32'(2));
        check("mid_busy_before_rst", 32'(busy), 32'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_count", 32'(count), 32'(0));
        check("mid_rst_tx_valid", 32'(tx_valid), 32'(0));
        repeat (12) @(negedge clk);

        // Randomized rounds against the model
        do_reset(2);
        hold_fixed = 0;
        for (int r = 0; r < 8; r++) begin
            k = int'($urandom_range(0, 20));
            for (int j = 0; j < k; j++) begin
                push(8'($urandom));
                if ($urandom_range(0, 2) == 0) @(negedge clk);
            end
            trigger = 1'b1;
            repeat ($urandom_range(1, 4)) @(negedge clk);
            trigger = 1'b0;
            drain(3000, 1'b1);
            check($sformatf("rand%0d_count", r), 32'(count), 32'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        failures++;
        $display("FAIL watchdog: got no completion by %0t, required finish", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
